// File: rtl/debounce_pkg.sv
// Shared types and helpers for the delayed debouncer.
package debounce_pkg;

  // Moore states: ZERO and WAIT1 drive 0, ONE and WAIT0 drive 1.
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // 20 ms at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;

  // Timer width of ceil(log2(cycles)) bits, never narrower than one bit.
  function automatic int timer_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Up-counter that measures how long sync_in has held one level in a WAIT state.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int TW = timer_width(DEBOUNCE_CYCLES);

  // The sample that enters the WAIT state is the first stable one, so the
  // interval is complete once DEBOUNCE_CYCLES-1 further samples are seen,
  // i.e. on the sample taken while the count reads DEBOUNCE_CYCLES-2.
  localparam logic [TW-1:0] LAST = TW'(DEBOUNCE_CYCLES - 2);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Clear has priority; otherwise count up while enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register; the FSM always leaves WAIT at LAST, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == LAST);

endmodule

// File: rtl/delayed_debouncer.sv
// Delayed-response switch debouncer: synchronizer, four-state Moore FSM, timer.
module delayed_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic debounced
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_in;

  state_t state_q;
  state_t state_d;
  logic   debounced_q;
  logic   debounced_d;

  logic timer_clear;
  logic timer_en;
  logic timer_done;

  // Shift the raw level into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], noisy};
  end

  // Synchronizer flops; cleared on reset so a high level at release looks new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Next-state logic; any opposite-level sample in a WAIT state aborts it.
  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ZERO: begin
        if (sync_in) begin
          state_d     = WAIT1;
          timer_clear = 1'b1;
        end
      end
      WAIT1: begin
        if (!sync_in) begin
          state_d = ZERO;
        end else if (timer_done) begin
          state_d = ONE;
        end else begin
          timer_en = 1'b1;
        end
      end
      ONE: begin
        if (!sync_in) begin
          state_d     = WAIT0;
          timer_clear = 1'b1;
        end
      end
      WAIT0: begin
        if (sync_in) begin
          state_d = ONE;
        end else if (timer_done) begin
          state_d = ZERO;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
    debounced_d = (state_d == ONE) || (state_d == WAIT0);
  end

  // State and output registers; the output is a flop, never a gate from noisy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ZERO;
      debounced_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      debounced_q <= debounced_d;
    end
  end

  debounce_timer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .en   (timer_en),
    .done (timer_done)
  );

  assign debounced = debounced_q;

endmodule

// File: tb/tb_delayed_debouncer.sv
// Bench for delayed_debouncer: output edges are scoreboarded by cycle and level.
module tb_delayed_debouncer;

  localparam int DC   = 32;
  localparam int SS   = 2;
  localparam int LAT  = SS + DC - 1;
  localparam int DCG  = 4;
  localparam int LATG = SS + DCG - 1;

  typedef struct {
    int   cycle;
    logic value;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic noisy;
  logic debounced;
  logic noisy_g;
  logic debounced_g;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t sb_g[$];
  logic prev = 1'b0;
  logic prev_g = 1'b0;

  delayed_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .noisy    (noisy),
    .debounced(debounced)
  );

  delayed_debouncer #(
    .DEBOUNCE_CYCLES(DCG),
    .SYNC_STAGES    (SS)
  ) dut_g (
    .clk      (clk),
    .reset    (reset),
    .noisy    (noisy_g),
    .debounced(debounced_g)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc is the number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive noisy; optionally predict the output edge this level will cause
  task automatic apply_stimulus(input logic v, input bit expect_edge);
    noisy = v;
    if (expect_edge) sb.push_back('{cyc + 1 + LAT, v});
  endtask

  // Main monitor: every output edge must match the oldest prediction
  always @(negedge clk) begin
    if (debounced !== prev) begin
      if (sb.size() == 0) begin
        check_bit("main_unexpected_edge", debounced, prev);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_int("main_edge_cycle", cyc, e.cycle);
        check_bit("main_edge_value", debounced, e.value);
      end
      prev = debounced;
    end
  end

  // Short-interval monitor
  always @(negedge clk) begin
    if (debounced_g !== prev_g) begin
      if (sb_g.size() == 0) begin
        check_bit("g_unexpected_edge", debounced_g, prev_g);
      end else begin
        exp_t e;
        e = sb_g.pop_front();
        check_int("g_edge_cycle", cyc, e.cycle);
        check_bit("g_edge_value", debounced_g, e.value);
      end
      prev_g = debounced_g;
    end
  end

  initial begin
    int n0;
    reset   = 1'b1;
    noisy   = 1'b0;
    noisy_g = 1'b0;
    wait_cycles(3);
    check_bit("reset_debounced", debounced, 1'b0);
    check_bit("reset_debounced_g", debounced_g, 1'b0);
    reset = 1'b0;
    wait_cycles(4);
    check_bit("idle_low", debounced, 1'b0);

    // Clean rise with full latency
    apply_stimulus(1'b1, 1'b1);
    wait_cycles(LAT);
    check_bit("t1_not_early", debounced, 1'b0);
    wait_cycles(1);
    check_bit("t1_rise", debounced, 1'b1);
    wait_cycles(78);
    check_bit("t1_hold", debounced, 1'b1);

    // Clean fall with the same latency
    apply_stimulus(1'b0, 1'b1);
    wait_cycles(80);
    check_bit("t2_low", debounced, 1'b0);

    // Bounce from 0, five toggles ending high
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(((i % 2) == 0), (i == 4));
      wait_cycles(2);
    end
    check_bit("t3_during_bounce", debounced, 1'b0);
    wait_cycles(40);
    check_bit("t3_high", debounced, 1'b1);

    // Bounce from 1, six toggles ending high: no output change
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(((i % 2) == 1), 1'b0);
      wait_cycles(2);
    end
    wait_cycles(40);
    check_bit("t4_held", debounced, 1'b1);

    // Return to 0, then reset midway through WAIT1
    apply_stimulus(1'b0, 1'b1);
    wait_cycles(40);
    check_bit("t5_low", debounced, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    wait_cycles(16);
    reset = 1'b1;
    wait_cycles(3);
    check_bit("t5_in_reset", debounced, 1'b0);
    reset = 1'b0;
    sb.push_back('{cyc + 1 + LAT, 1'b1});
    wait_cycles(LAT);
    check_bit("t5_not_early", debounced, 1'b0);
    wait_cycles(2);
    check_bit("t5_rise", debounced, 1'b1);

    // Short interval: one-cycle low glitch on the last WAIT1 sample
    n0 = cyc;
    noisy_g = 1'b1;
    wait_cycles(3);
    noisy_g = 1'b0;
    wait_cycles(1);
    noisy_g = 1'b1;
    sb_g.push_back('{cyc + 1 + LATG, 1'b1});
    wait_cycles(3);
    check_int("g_glitch_cycle", cyc, n0 + 7);
    check_bit("g_after_glitch", debounced_g, 1'b0);
    wait_cycles(5);
    check_bit("g_rise", debounced_g, 1'b1);

    check_int("main_sb_empty", sb.size(), 0);
    check_int("g_sb_empty", sb_g.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
